// File: rtl/switch_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | switch_debouncer: 2-FF sync + per-bit counter debounce with change strobes |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] swt_raw,
  output logic [WIDTH-1:0] swt,
  output logic [WIDTH-1:0] swt_rise,
  output logic [WIDTH-1:0] swt_fall,
  output logic             swt_changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] swt_q, swt_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Any sample agreeing with the accepted level discards the partial count.
  always_comb begin
    swt_d  = swt_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == swt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        swt_d[i]  = s2_q[i];
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    changed_d = |{rise_d, fall_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      swt_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= swt_raw;
      s2_q      <= s1_q;
      swt_q     <= swt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign swt         = swt_q;
  assign swt_rise    = rise_q;
  assign swt_fall    = fall_q;
  assign swt_changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_switch_debouncer: scoreboard + table-driven bench for switch_debouncer  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_switch_debouncer;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] swt_raw = '0;
  logic [W-1:0] swt, swt_rise, swt_fall;
  logic         swt_changed;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .swt_raw(swt_raw), .swt(swt),
    .swt_rise(swt_rise), .swt_fall(swt_fall), .swt_changed(swt_changed)
  );

  typedef struct packed {
    logic [W-1:0] swt;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } obs_t;

  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] exp_swt;
    int           exp_chg;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
  } vec_t;

  int errors = 0;
  int checks = 0;

  obs_t         exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_swt = '0;
  obs_t         last_obs;
  int           seg_chg;
  logic [W-1:0] seg_rise, seg_fall;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Level seen at the debounce input k edges before the current one.
  function automatic logic [W-1:0] s2_at(input int k);
    int idx;
    idx = hist.size() - 3 - k;
    if (idx < 0) return '0;
    return hist[idx];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_swt = '0;
  endtask

  // Drive one raw value for one clock; called and returns at a negedge.
  task automatic step(input logic [W-1:0] raw);
    obs_t         e, got;
    logic [W-1:0] tog;
    swt_raw = raw;
    hist.push_back(raw);
    if (hist.size() > D + 2) void'(hist.pop_front());
    tog = '1;
    for (int k = 0; k < D; k++) tog &= s2_at(k) ^ m_swt;
    e.rise = tog & ~m_swt;
    e.fall = tog & m_swt;
    m_swt  = m_swt ^ tog;
    e.swt  = m_swt;
    e.chg  = |tog;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {swt, swt_rise, swt_fall, swt_changed};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL cycle: swt/rise/fall/chg got=%h/%h/%h/%b expected=%h/%h/%h/%b at %0t",
               got.swt, got.rise, got.fall, got.chg, e.swt, e.rise, e.fall, e.chg, $time);
    end
    last_obs = got;
    if (swt_changed) begin
      seg_chg++;
      seg_rise = swt_rise;
      seg_fall = swt_fall;
    end
    @(negedge clk);
  endtask

  task automatic seg_clear();
    seg_chg  = 0;
    seg_rise = '0;
    seg_fall = '0;
  endtask

  vec_t tbl[$];

  initial begin
    int k;
    logic [W-1:0] v;

    tbl.push_back('{8'h00, 8, 8'h00, 1, 8'h00, 8'hFF});
    tbl.push_back('{8'h01, 3, 8'h00, 0, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 8, 8'h00, 0, 8'h00, 8'h00});
    tbl.push_back('{8'h01, 4, 8'h00, 0, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 5, 8'h01, 1, 8'h01, 8'h00});
    tbl.push_back('{8'h00, 1, 8'h00, 1, 8'h00, 8'h01});
    tbl.push_back('{8'h02, 8, 8'h02, 1, 8'h02, 8'h00});
    tbl.push_back('{8'h80, 8, 8'h80, 1, 8'h80, 8'h02});
    tbl.push_back('{8'h00, 8, 8'h00, 1, 8'h00, 8'h80});

    // Reset asserted while pins are high
    swt_raw = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset_swt", {24'h0, swt}, 32'h0);
    chk("reset_strobes", {15'h0, swt_rise, swt_fall, swt_changed}, 32'h0);
    model_reset();
    rst_n = 1'b1;
    seg_clear();
    for (int i = 1; i <= 7; i++) begin
      step(8'hFF);
      if (i == 5) chk("rel_edge5_swt", {24'h0, last_obs.swt}, 32'h00);
      if (i == 6) begin
        chk("rel_edge6_swt", {24'h0, last_obs.swt}, 32'hFF);
        chk("rel_edge6_rise", {24'h0, last_obs.rise}, 32'hFF);
        chk("rel_edge6_chg", {31'h0, last_obs.chg}, 32'h1);
      end
      if (i == 7) chk("rel_edge7_rise", {24'h0, last_obs.rise}, 32'h00);
    end

    // Glitch, threshold and simultaneous-change vectors
    foreach (tbl[t]) begin
      seg_clear();
      repeat (tbl[t].hold) step(tbl[t].raw);
      chk($sformatf("vec%0d_swt", t), {24'h0, last_obs.swt}, {24'h0, tbl[t].exp_swt});
      chk($sformatf("vec%0d_nchg", t), seg_chg, tbl[t].exp_chg);
      chk($sformatf("vec%0d_rise", t), {24'h0, seg_rise}, {24'h0, tbl[t].exp_rise});
      chk($sformatf("vec%0d_fall", t), {24'h0, seg_fall}, {24'h0, tbl[t].exp_fall});
    end

    // Bounce on bit 3
    seg_clear();
    for (int c = 0; c < 20; c++) step(((c / 2) % 2 == 0) ? 8'h08 : 8'h00);
    chk("bounce_no_accept", seg_chg, 0);
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      step(8'h08);
      if (k == 0 && last_obs.swt[3]) k = c;
    end
    chk("bounce_latency", k, 6);
    chk("bounce_one_rise", seg_chg, 1);
    chk("bounce_rise_bit", {24'h0, seg_rise}, 32'h08);
    repeat (8) step(8'h00);

    // Reset in the middle of a count
    repeat (4) step(8'h20);
    rst_n = 1'b0;
    #1;
    chk("midreset_async", {7'h0, swt, swt_rise, swt_fall, swt_changed}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seg_clear();
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      step(8'h20);
      if (k == 0 && last_obs.swt[5]) k = c;
    end
    chk("midreset_latency", k, 6);
    chk("midreset_one_rise", seg_chg, 1);

    // Sweep of even values
    for (int n = 0; n < 128; n++) begin
      v = 8'(2 * n);
      seg_clear();
      for (int c = 1; c <= 10; c++) begin
        step(v);
        if (c == 5 && last_obs.swt == v) begin
          errors++;
          checks++;
          $display("FAIL sweep_early: value %0h accepted before edge 6", v);
        end
        if (c == 6) begin
          checks++;
          if (last_obs.swt !== v) begin
            errors++;
            $display("FAIL sweep_edge6: got=%0h expected=%0h", last_obs.swt, v);
          end
        end
      end
      checks++;
      if (seg_chg != 1) begin
        errors++;
        $display("FAIL sweep_nchg: value %0h got=%0d expected=1", v, seg_chg);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
